// File: rtl/piso_8_bit_tx_if.sv
// Load/serial bundle for piso_8_bit_tx: master offers bytes and paces the bit rate,
// slave (the transmitter) returns the handshake and the serial stream.
interface piso_8_bit_tx_if;
    logic       enable;
    logic       load_valid;
    logic [7:0] din;
    logic       load_ready;
    logic       data;
    logic       frame;
    logic       done;

    modport master (
        output enable, load_valid, din,
        input  load_ready, data, frame, done
    );

    modport slave (
        input  enable, load_valid, din,
        output load_ready, data, frame, done
    );
endinterface

// File: rtl/piso_8_bit_tx.sv
// 8-bit parallel-in serial-out transmitter, MSB first, one bit per enabled clk edge.
// Define PISO_TX_PARITY_EN to append an even-parity bit as a ninth frame bit.
module piso_8_bit_tx #(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input logic             clk,
    input logic             reset,
    piso_8_bit_tx_if.slave  bus
);

`ifdef PISO_TX_PARITY_EN
    localparam logic [3:0] LastIdx = 4'd8;
`else
    localparam logic [3:0] LastIdx = 4'd7;
`endif

    typedef enum logic {StIdle, StShift} state_t;

    state_t     state_q, state_d;
    logic       data_q, data_d;
    logic       frame_q, frame_d;
    logic       done_q, done_d;
    logic [3:0] cnt_q, cnt_d;
    logic [6:0] sr_q, sr_d;
`ifdef PISO_TX_PARITY_EN
    logic       parity_q, parity_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            data_q   <= IDLE_LEVEL;
            frame_q  <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= 4'd0;
            sr_q     <= 7'd0;
`ifdef PISO_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            frame_q  <= frame_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
`ifdef PISO_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        frame_d  = frame_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
`ifdef PISO_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Accept does not wait for enable; the first bit goes out immediately.
                if (bus.load_valid) begin
                    state_d  = StShift;
                    data_d   = bus.din[7];
                    sr_d     = bus.din[6:0];
                    cnt_d    = 4'd0;
                    frame_d  = 1'b1;
`ifdef PISO_TX_PARITY_EN
                    parity_d = ^bus.din;
`endif
                end
            end
            StShift: begin
                if (bus.enable) begin
                    if (cnt_q == LastIdx) begin
                        state_d = StIdle;
                        data_d  = IDLE_LEVEL;
                        frame_d = 1'b0;
                        done_d  = 1'b1;
                        cnt_d   = 4'd0;
`ifdef PISO_TX_PARITY_EN
                    end else if (cnt_q == 4'd7) begin
                        data_d  = parity_q;
                        cnt_d   = 4'd8;
`endif
                    end else begin
                        data_d  = sr_q[6];
                        sr_d    = {sr_q[5:0], 1'b0};
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.load_ready = (state_q == StIdle);
    assign bus.data       = data_q;
    assign bus.frame      = frame_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_8_bit_tx.sv
// Scoreboard bench for piso_8_bit_tx: stimulus queues expected bits/bytes on each accept,
// a negedge monitor acts as serial receiver and compares against the queues.
module tb_piso_8_bit_tx;

    localparam logic IdleLevel = 1'b0;
`ifdef PISO_TX_PARITY_EN
    localparam int FrameLen = 9;
`else
    localparam int FrameLen = 8;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    piso_8_bit_tx_if bus ();

    piso_8_bit_tx #(.IDLE_LEVEL(IdleLevel)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int         checks = 0;
    int         errors = 0;
    bit         exp_bits[$];
    logic [7:0] exp_bytes[$];
    int         accept_cyc[$];
    int         bits_left = 0;
    bit         pending = 1'b0;
    bit         done_exp = 1'b0;
    int         accepts = 0;
    int         cyc = 0;
    logic [8:0] rx = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected serial stream for one accepted byte, straight from the frame definition.
    task automatic push_frame(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
`ifdef PISO_TX_PARITY_EN
        exp_bits.push_back(^b);
`endif
        exp_bytes.push_back(b);
        accept_cyc.push_back(cyc + 1);
        pending = 1'b1;
        accepts++;
    endtask

    task automatic drive(input bit en, input bit lv, input logic [7:0] d, input bit noise);
        @(posedge clk);
        #1;
        if (noise && bits_left == 0) lv = 1'b0;
        bus.enable     = en;
        bus.load_valid = lv;
        bus.din        = d;
        if (lv && !reset && bits_left == 0 && !pending) push_frame(d);
    endtask

    // period 0: random enable; otherwise enable every period-th cycle.
    task automatic wait_idle(input int period, input bit noise);
        int n = 0;
        bit en;
        while ((bits_left != 0 || pending) && n < 400) begin
            en = (period == 0) ? 1'($urandom % 2) : (n % period == 0);
            drive(en, noise ? 1'($urandom % 2) : 1'b0, noise ? 8'($urandom) : 8'h00, noise);
            n++;
        end
        chk(n < 400, "frame_timeout", n, 400);
    endtask

    task automatic send(input logic [7:0] b, input int period, input bit noise);
        wait_idle(1, 1'b0);
        drive(1'($urandom % 2), 1'b1, b, 1'b0);
        wait_idle(period, noise);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk(bus.data == IdleLevel, "rst_data", bus.data, IdleLevel);
            chk(bus.frame == 1'b0, "rst_frame", bus.frame, 0);
            chk(bus.done == 1'b0, "rst_done", bus.done, 0);
            chk(bus.load_ready == 1'b1, "rst_ready", bus.load_ready, 1);
            exp_bits.delete();
            exp_bytes.delete();
            bits_left = 0;
            pending   = 1'b0;
            done_exp  = 1'b0;
        end else begin
            chk(bus.load_ready == (bits_left == 0), "load_ready", bus.load_ready,
                int'(bits_left == 0));
            chk(bus.frame == (bits_left > 0), "frame", bus.frame, int'(bits_left > 0));
            chk(bus.done == done_exp, "done", bus.done, done_exp);
            if (done_exp && exp_bytes.size() > 0) begin
`ifdef PISO_TX_PARITY_EN
                chk(rx[8:1] == exp_bytes[0], "rx_byte", rx[8:1], exp_bytes[0]);
`else
                chk(rx[7:0] == exp_bytes[0], "rx_byte", rx[7:0], exp_bytes[0]);
`endif
                void'(exp_bytes.pop_front());
            end
            done_exp = 1'b0;
            if (bits_left == 0) begin
                chk(bus.data == IdleLevel, "idle_data", bus.data, IdleLevel);
            end else if (exp_bits.size() > 0) begin
                chk(bus.data == exp_bits[0], "serial_bit", bus.data, exp_bits[0]);
                // Bit on data is retired by the coming edge only when enable is high.
                if (bus.enable) begin
                    rx = {rx[7:0], bus.data};
                    void'(exp_bits.pop_front());
                    bits_left--;
                    if (bits_left == 0) done_exp = 1'b1;
                end
            end
            if (pending) begin
                bits_left = FrameLen;
                pending   = 1'b0;
                rx        = '0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0;
        int n;
        bus.enable     = 1'b0;
        bus.load_valid = 1'b0;
        bus.din        = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        send(8'hA5, 1, 1'b0);
        send(8'h3C, 3, 1'b0);
        send(8'hFF, 1, 1'b1);
        send(8'h00, 2, 1'b1);

        // Abort a frame after its fourth enabled edge.
        wait_idle(1, 1'b0);
        drive(1'b1, 1'b1, 8'h81, 1'b0);
        n = 0;
        while (bits_left != FrameLen - 4 && n < 50) begin
            drive(1'b1, 1'b0, 8'h00, 1'b0);
            n++;
        end
        chk(n < 50, "abort_timeout", n, 50);
        reset = 1'b1;
        #1;
        chk(bus.data == IdleLevel, "async_rst_data", bus.data, IdleLevel);
        chk(bus.frame == 1'b0, "async_rst_frame", bus.frame, 0);
        chk(bus.load_ready == 1'b1, "async_rst_ready", bus.load_ready, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        bus.enable = 1'b0;
        send(8'h42, 1, 1'b0);

        // Back-to-back: load_valid held high across two frames.
        a0 = accepts;
        drive(1'b1, 1'b1, 8'h12, 1'b0);
        n = 0;
        while (accepts < a0 + 2 && n < 50) begin
            drive(1'b1, 1'b1, 8'h34, 1'b0);
            n++;
        end
        chk(accepts == a0 + 2, "b2b_accepts", accepts, a0 + 2);
        if (accept_cyc.size() >= 2)
            chk(accept_cyc[$] - accept_cyc[$-1] == FrameLen + 1, "b2b_spacing",
                accept_cyc[$] - accept_cyc[$-1], FrameLen + 1);
        wait_idle(1, 1'b0);

        repeat (24) send(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom % 2));

        repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk(exp_bytes.size() == 0, "frames_outstanding", exp_bytes.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
